// File: rtl/calc_sequencer.sv
// Sequencing controller for the four-function calculator datapath.
// Latches the selected operation, runs add/sub/shift-add multiply, and drives the display refresh select.
module calc_sequencer #(
    parameter int WIDTH   = 4,
    parameter int REFRESH = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 add,
    input  logic                 sub,
    input  logic                 mult,
    input  logic                 squared,
    input  logic                 start,
    output logic [2:0]           op_code,
    output logic [2*WIDTH-1:0]   result,
    output logic                 sign,
    output logic                 busy,
    output logic                 done,
    output logic                 sel
);

    localparam int RWID = 2 * WIDTH;
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
    localparam int RW   = (REFRESH > 2) ? $clog2(REFRESH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MULT = 3'd3,
        OP_SQR  = 3'd4
    } op_t;

    state_t            state;
    op_t               op_sel;
    op_t               op_run;
    op_t               op_next;
    logic [WIDTH-1:0]  a_lat;
    logic [WIDTH-1:0]  b_lat;
    logic [WIDTH-1:0]  mplier;
    logic [RWID-1:0]   mcand;
    logic [RWID-1:0]   acc;
    logic [RWID-1:0]   acc_step;
    logic [RWID-1:0]   sum;
    logic [WIDTH-1:0]  mag_diff;
    logic              a_lt_b;
    logic [CW-1:0]     step_cnt;
    logic [RW-1:0]     refresh_cnt;

    assign op_code = op_sel;

    always_comb begin
        op_next = op_sel;
        if (squared)
            op_next = OP_SQR;
        else if (mult)
            op_next = OP_MULT;
        else if (sub)
            op_next = OP_SUB;
        else if (add)
            op_next = OP_ADD;
    end

    always_comb begin
        sum      = RWID'(a_lat) + RWID'(b_lat);
        a_lt_b   = (a_lat < b_lat);
        mag_diff = a_lt_b ? (b_lat - a_lat) : (a_lat - b_lat);
        acc_step = mplier[0] ? (acc + mcand) : acc;
    end

    // op_run snapshots op_sel at launch so a same-cycle button press only affects the next launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_sel   <= OP_NONE;
            op_run   <= OP_NONE;
            a_lat    <= '0;
            b_lat    <= '0;
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
            step_cnt <= '0;
            result   <= '0;
            sign     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    op_sel <= op_next;
                    if (start && (op_sel != OP_NONE)) begin
                        a_lat    <= a;
                        b_lat    <= b;
                        op_run   <= op_sel;
                        mcand    <= RWID'(a);
                        mplier   <= (op_sel == OP_SQR) ? a : b;
                        acc      <= '0;
                        step_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_run)
                        OP_ADD: begin
                            result <= sum;
                            sign   <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                        OP_SUB: begin
                            result <= RWID'(mag_diff);
                            sign   <= a_lt_b;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                        default: begin
                            acc      <= acc_step;
                            mcand    <= mcand << 1;
                            mplier   <= mplier >> 1;
                            step_cnt <= step_cnt + CW'(1);
                            if (step_cnt == CW'(WIDTH - 1)) begin
                                result <= acc_step;
                                sign   <= 1'b0;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                state  <= DONE;
                            end
                        end
                    endcase
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            sel         <= 1'b0;
        end else if (refresh_cnt == RW'(REFRESH - 1)) begin
            refresh_cnt <= '0;
            sel         <= ~sel;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (WIDTH=4, REFRESH=4) with immediate-assertion checks.
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic       add;
    logic       sub;
    logic       mult;
    logic       squared;
    logic       start;
    logic [2:0] op_code;
    logic [7:0] result;
    logic       sign;
    logic       busy;
    logic       done;
    logic       sel;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    bit sel_en = 1'b0;

    calc_sequencer #(.WIDTH(4), .REFRESH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .add     (add),
        .sub     (sub),
        .mult    (mult),
        .squared (squared),
        .start   (start),
        .op_code (op_code),
        .result  (result),
        .sign    (sign),
        .busy    (busy),
        .done    (done),
        .sel     (sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles since the last reset edge; sel should read (cyc / 4) mod 2.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (sel_en) check("sel_model", {31'd0, sel}, {31'd0, 1'((cyc / 4) % 2)});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic p_add, input logic p_sub, input logic p_mult, input logic p_sq);
        add = p_add; sub = p_sub; mult = p_mult; squared = p_sq;
        step();
        add = 0; sub = 0; mult = 0; squared = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_op"},     {29'd0, op_code}, 32'd0);
        check({tag, "_result"}, {24'd0, result},  32'd0);
        check({tag, "_sign"},   {31'd0, sign},    32'd0);
        check({tag, "_busy"},   {31'd0, busy},    32'd0);
        check({tag, "_done"},   {31'd0, done},    32'd0);
        check({tag, "_sel"},    {31'd0, sel},     32'd0);
    endtask

    initial begin
        reset = 1; a = 0; b = 0; add = 0; sub = 0; mult = 0; squared = 0; start = 0;
        step();
        step();
        reset = 0;
        sel_en = 1'b1;
        check_reset_vals("rst");

        // sel first rises 4 cycles after reset deasserts
        step(); step(); step();
        check("sel_pre_rise", {31'd0, sel}, 32'd0);
        step();
        check("sel_first_rise", {31'd0, sel}, 32'd1);

        // add 3 + 5
        press(1, 0, 0, 0);
        check("add_op", {29'd0, op_code}, 32'd1);
        a = 3; b = 5; start = 1;
        step();
        start = 0;
        check("add_busy_c1", {31'd0, busy}, 32'd1);
        check("add_done_c1", {31'd0, done}, 32'd0);
        step();
        check("add_done_c2", {31'd0, done}, 32'd1);
        check("add_busy_c2", {31'd0, busy}, 32'd0);
        check("add_result", {24'd0, result}, 32'd8);
        check("add_sign", {31'd0, sign}, 32'd0);
        step();
        check("add_done_c3", {31'd0, done}, 32'd0);
        check("add_result_hold", {24'd0, result}, 32'd8);

        // subtract positive, then back-to-back negative
        press(0, 1, 0, 0);
        check("sub_op", {29'd0, op_code}, 32'd2);
        a = 7; b = 2; start = 1;
        step();
        start = 0;
        check("subp_busy", {31'd0, busy}, 32'd1);
        step();
        check("subp_done", {31'd0, done}, 32'd1);
        check("subp_result", {24'd0, result}, 32'd5);
        check("subp_sign", {31'd0, sign}, 32'd0);
        step();
        a = 2; b = 7; start = 1;
        step();
        start = 0;
        check("subn_busy", {31'd0, busy}, 32'd1);
        step();
        check("subn_done", {31'd0, done}, 32'd1);
        check("subn_result", {24'd0, result}, 32'd5);
        check("subn_sign", {31'd0, sign}, 32'd1);
        step();
        check("subn_sign_hold", {31'd0, sign}, 32'd1);

        // multiply 15 * 15 with operand changes and ignored buttons mid-run
        press(0, 0, 1, 0);
        check("mult_op", {29'd0, op_code}, 32'd3);
        a = 15; b = 15; start = 1;
        step();
        start = 0;
        a = 0; b = 0;
        for (int i = 0; i < 4; i++) begin
            check("mult_busy", {31'd0, busy}, 32'd1);
            check("mult_nodone", {31'd0, done}, 32'd0);
            if (i == 1) begin
                sub = 1; start = 1;
            end else begin
                sub = 0; start = 0;
            end
            step();
        end
        sub = 0; start = 0;
        check("mult_done", {31'd0, done}, 32'd1);
        check("mult_busy_off", {31'd0, busy}, 32'd0);
        check("mult_result", {24'd0, result}, 32'd225);
        check("mult_sign", {31'd0, sign}, 32'd0);
        check("mult_op_kept", {29'd0, op_code}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mult_single_done", {31'd0, done}, 32'd0);
            check("mult_no_relaunch", {31'd0, busy}, 32'd0);
        end

        // squared 9 -> 81, b ignored
        press(0, 0, 0, 1);
        check("sq_op", {29'd0, op_code}, 32'd4);
        a = 9; b = 3; start = 1;
        step();
        start = 0;
        b = 15;
        for (int i = 0; i < 4; i++) begin
            check("sq_busy", {31'd0, busy}, 32'd1);
            step();
        end
        check("sq_done", {31'd0, done}, 32'd1);
        check("sq_result", {24'd0, result}, 32'd81);
        step();

        // add+mult together -> mult priority
        press(1, 0, 1, 0);
        check("prio_op", {29'd0, op_code}, 32'd3);

        // button with start in same cycle: launch uses old op (mult 2*3)
        a = 2; b = 3; add = 1; start = 1;
        step();
        add = 0; start = 0;
        check("same_cyc_op", {29'd0, op_code}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("same_cyc_busy", {31'd0, busy}, 32'd1);
            step();
        end
        check("same_cyc_done", {31'd0, done}, 32'd1);
        check("same_cyc_result", {24'd0, result}, 32'd6);
        step();

        // reset in cycle 2 of a multiply
        press(0, 0, 1, 0);
        a = 3; b = 3; start = 1;
        step();
        start = 0;
        step();
        check("rmid_busy", {31'd0, busy}, 32'd1);
        reset = 1;
        step();
        reset = 0;
        check_reset_vals("rmid");
        for (int i = 0; i < 6; i++) begin
            check("rmid_no_done", {31'd0, done}, 32'd0);
            step();
        end

        // start with op_code 0 is ignored
        start = 1;
        step();
        start = 0;
        check("nop_busy", {31'd0, busy}, 32'd0);
        step();
        check("nop_done", {31'd0, done}, 32'd0);
        check("nop_result", {24'd0, result}, 32'd0);

        // add after reset: 15 + 15
        press(1, 0, 0, 0);
        a = 15; b = 15; start = 1;
        step();
        start = 0;
        check("add2_busy", {31'd0, busy}, 32'd1);
        step();
        check("add2_done", {31'd0, done}, 32'd1);
        check("add2_result", {24'd0, result}, 32'd30);
        check("add2_sign", {31'd0, sign}, 32'd0);
        step();
        step();

        sel_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencing controller for the four-function calculator datapath: latches the operation selected by the add/sub/mult/squared buttons and samples the operands on a start pulse. Runs the operation (single-cycle add/subtract, iterative shift-add multiply/square) and holds the result with a done strobe. Also owns the free-running refresh counter that drives the two-digit display mux select.

## Interface

**Parameters**
- `WIDTH`, default 4: operand width in bits.
- `REFRESH`, default 100000: clock cycles per display digit before `sel` toggles. Must be ≥ 2.

**Ports**
- `clk`, input, 1: single system clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `a`, input, WIDTH: operand A, unsigned.
- `b`, input, WIDTH: operand B, unsigned; ignored for squared.
- `add`, `sub`, `mult`, `squared`, input, 1 each: operation select pulses (debounced level or pulse).
- `start`, input, 1: launch request, sampled each cycle.
- `op_code`, output, 3: latched operation; 0 none, 1 add, 2 sub, 3 mult, 4 squared.
- `result`, output, 2*WIDTH: magnitude of the last result.
- `sign`, output, 1: 1 when the last subtract was negative (a < b); 0 otherwise.
- `busy`, output, 1: high while in EXEC.
- `done`, output, 1: one-cycle strobe when `result` is updated.
- `sel`, output, 1: display digit select for the anode mux.

## Operation

- States: IDLE, EXEC, DONE.
- **IDLE**
  - Op buttons load `op_code` with fixed priority: squared > mult > sub > add.
  - `start` with `op_code` ≠ 0: latch `a` and `b` internally, then go to EXEC.
  - `start` with `op_code` = 0 is ignored.
- **EXEC (add)**: result = zero-extended a + b; sign = 0; go to DONE after 1 cycle.
- **EXEC (sub)**
  - a ≥ b: result = a − b, sign = 0.
  - a < b: result = b − a, sign = 1.
  - Go to DONE after 1 cycle.
- **EXEC (mult/squared)**
  - Shift-add over exactly WIDTH cycles on the latched operands; multiplier = b for mult, a for squared.
  - Uses a 2*WIDTH accumulator; overflow is impossible; sign = 0.
- **DONE**: `done` = 1 for this cycle; unconditionally return to IDLE next cycle.
- **Held values**
  - `result` and `sign` change only on the edge that enters DONE. They hold until the next completed operation.
  - `op_code` holds across operations until a new button press in IDLE.
- **Ignored inputs**: op buttons and `start` are ignored in EXEC and DONE. Changes on `a` and `b` after launch do not affect the running operation.
- **Refresh counter**
  - Counts 0 … REFRESH−1 and wraps; `sel` toggles on each wrap.
  - Independent of the FSM state and never paused.

## Timing

- **Reset values** (a reset edge overrides everything, including mid-EXEC):
  - State IDLE.
  - `op_code` = 0, `result` = 0, `sign` = 0, `busy` = 0, `done` = 0, `sel` = 0.
  - Refresh counter = 0; multiplier accumulator and shift registers cleared.
- **Cycle numbering**: cycle 0 is the edge on which `start` is sampled in IDLE.
- **Add/sub**: `busy` = 1 in cycle 1; `done` = 1 and `result` valid in cycle 2; IDLE in cycle 3.
- **Mult/squared**: `busy` = 1 in cycles 1 … WIDTH; `done` = 1 and `result` valid in cycle WIDTH+1; IDLE in cycle WIDTH+2.
- **Back-to-back starts**: the earliest next accepted `start` is the first cycle back in IDLE.
- **Button and start on the same IDLE cycle**: the button updates `op_code`, and `start` launches with the previous `op_code`. The new `op_code` applies to the next launch.
- **Multiple op buttons in one cycle**: the priority rule applies.
- **Display select**: with the counter at REFRESH−1, the next edge wraps it to 0 and toggles `sel`. After reset, the first toggle occurs REFRESH cycles after reset deasserts.

## Test plan

- **Add**: reset, pulse `add`, a=3, b=5, `start` → `op_code`=1; `busy` in cycle 1; `done` in cycle 2 with `result`=8, `sign`=0.
- **Subtract, negative result**: pulse `sub`, a=2, b=7, `start` → `result`=5, `sign`=1 in cycle 2. Then a=7, b=2, `start` → `result`=5, `sign`=0.
- **Multiply and square (WIDTH=4)**:
  - `mult`, a=15, b=15 → `busy` in cycles 1–4; `done` in cycle 5 with `result`=225.
  - `squared`, a=9, b=3 → `result`=81.
- **Priority and ignored inputs**:
  - `add` and `mult` pressed together → `op_code`=3.
  - During EXEC, pulse `sub` and `start` → no effect on `op_code` or the running operation; a single `done`.
  - `start` with `op_code`=0 → stays IDLE.
- **Reset mid-operation**: assert `reset` in cycle 2 of a multiply → next cycle all outputs at reset values, no `done` strobe. A subsequent add completes normally.
- **Display refresh (REFRESH=4)**: `sel` toggles exactly every 4 cycles during idle and during EXEC, and first rises 4 cycles after reset deasserts.
